// File: rtl/mealy_1101_pkg.sv
// Shared types for the 1101 serial pattern detector.
// Holds the state encoding and the pattern constant.
package mealy_1101_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_11   = 2'd2,
    S_110  = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/mealy_1101_if.sv
// Serial bit stream and detect flag bundle.
// Master drives the stream, slave reports the match.
interface mealy_1101_if;
  logic din;
  logic y;

  modport master (
    output din,
    input  y
  );

  modport slave (
    input  din,
    output y
  );
endinterface

// File: rtl/mealy_1101.sv
// Mealy detector for the serial pattern 1-1-0-1.
// Y is combinational from state and Din; OVERLAP picks restart state.
module mealy_1101
  import mealy_1101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Y
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (Din == PATTERN[3]) state_d = S_1;
        else                   state_d = S_IDLE;
      end
      S_1: begin
        if (Din == PATTERN[2]) state_d = S_11;
        else                   state_d = S_IDLE;
      end
      S_11: begin
        // A run of 1s keeps the "11" prefix alive
        if (Din == PATTERN[1]) state_d = S_110;
        else                   state_d = S_11;
      end
      S_110: begin
        if (Din == PATTERN[0])
          state_d = OVERLAP ? S_1 : S_IDLE;
        else
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AND form keeps Y at 0 for an unknown Din outside S_110
  assign Y = (state_q == S_110) & Din;

endmodule

// File: tb/tb_mealy_1101.sv
// Self-checking bench: both OVERLAP settings against a history model.
// Directed streams pin the model; random stream exercises the rest.
module tb_mealy_1101;

  logic Clk;
  logic Rst;

  mealy_1101_if bus_ov ();
  mealy_1101_if bus_no ();

  mealy_1101 #(.OVERLAP(1'b1)) dut_ov (
    .Clk (Clk),
    .Rst (Rst),
    .Din (bus_ov.din),
    .Y   (bus_ov.y)
  );

  mealy_1101 #(.OVERLAP(1'b0)) dut_no (
    .Clk (Clk),
    .Rst (Rst),
    .Din (bus_no.din),
    .Y   (bus_no.y)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nerr = 0;
  int nchk = 0;

  // Bits consumed since reset (overlap) or since reset/last match
  logic hist_ov[$];
  logic hist_no[$];

  function automatic logic tail_110(input logic q[$]);
    int n;
    n = q.size();
    if (n < 3) return 1'b0;
    return q[n-3] && q[n-2] && !q[n-1];
  endfunction

  function automatic logic exp_y(input bit ov, input logic d);
    if (ov) return (d === 1'b1) && tail_110(hist_ov);
    return (d === 1'b1) && tail_110(hist_no);
  endfunction

  task automatic check(input string nm, input logic act,
                       input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_din(input logic b);
    bus_ov.din = b;
    bus_no.din = b;
  endtask

  task automatic clear_model();
    hist_ov.delete();
    hist_no.delete();
  endtask

  task automatic consume(input logic b);
    logic m_no;
    m_no = exp_y(1'b0, b);
    hist_ov.push_back(b);
    if (hist_ov.size() > 8) void'(hist_ov.pop_front());
    if (m_no) begin
      hist_no.delete();
    end else begin
      hist_no.push_back(b);
      if (hist_no.size() > 8) void'(hist_no.pop_front());
    end
  endtask

  task automatic compare(input string nm);
    check({nm, "_ov"}, bus_ov.y, exp_y(1'b1, bus_ov.din));
    check({nm, "_no"}, bus_no.y, exp_y(1'b0, bus_no.din));
  endtask

  // One bit per clock, driven at the falling edge
  task automatic drive(input logic b, input string nm);
    @(negedge Clk);
    set_din(b);
    #1;
    compare(nm);
    @(posedge Clk);
    if (Rst) consume(b);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0;
    clear_model();
    set_din(1'b0);
    @(negedge Clk);
    #1;
    Rst = 1'b1;
  endtask

  // Directed stream with literal expectations for both variants
  task automatic run_stream(input string nm, input string bits,
                            input string eov, input string eno);
    logic b;
    do_reset();
    for (int i = 0; i < bits.len(); i++) begin
      b = (bits[i] == "1");
      @(negedge Clk);
      set_din(b);
      #1;
      compare(nm);
      check({nm, "_lit_ov"}, bus_ov.y, eov[i] == "1");
      check({nm, "_lit_no"}, bus_no.y, eno[i] == "1");
      @(posedge Clk);
      consume(b);
    end
  endtask

  initial begin
    Rst = 1'b0;
    set_din(1'b0);

    // Held in reset with Din toggling: no detect
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      set_din(i[0]);
      #1;
      check("rst_y_ov", bus_ov.y, 1'b0);
      check("rst_y_no", bus_no.y, 1'b0);
    end
    clear_model();
    @(negedge Clk);
    Rst = 1'b1;

    run_stream("basic", "01010111010101",
               "00000000010000", "00000000010000");
    run_stream("overlap", "1101101",
               "0001001", "0001000");
    run_stream("nearmiss", "11001101",
               "00000001", "00000001");

    // Mid-pattern asynchronous reset
    do_reset();
    drive(1'b1, "mid");
    drive(1'b1, "mid");
    drive(1'b0, "mid");
    @(negedge Clk);
    set_din(1'b1);
    #1;
    check("mid_pre_ov", bus_ov.y, 1'b1);
    check("mid_pre_no", bus_no.y, 1'b1);
    Rst = 1'b0;
    clear_model();
    #1;
    check("mid_async_ov", bus_ov.y, 1'b0);
    check("mid_async_no", bus_no.y, 1'b0);
    Rst = 1'b1;
    @(posedge Clk);
    consume(1'b1);
    drive(1'b1, "mid_tail");
    drive(1'b0, "mid_tail");
    @(negedge Clk);
    set_din(1'b1);
    #1;
    check("mid_match_ov", bus_ov.y, 1'b1);
    check("mid_match_no", bus_no.y, 1'b1);
    @(posedge Clk);
    consume(1'b1);

    // Y follows Din with no clock edge while in S_110
    do_reset();
    drive(1'b1, "mealy");
    drive(1'b1, "mealy");
    drive(1'b0, "mealy");
    @(negedge Clk);
    set_din(1'b0);
    #1;
    check("mealy_lo_ov", bus_ov.y, 1'b0);
    set_din(1'b1);
    #1;
    check("mealy_hi_ov", bus_ov.y, 1'b1);
    check("mealy_hi_no", bus_no.y, 1'b1);
    set_din(1'b0);
    #1;
    check("mealy_back_ov", bus_ov.y, 1'b0);
    check("mealy_back_no", bus_no.y, 1'b0);
    @(posedge Clk);
    consume(1'b0);

    // Random stream, biased toward 1s, with rare resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end
      drive($urandom_range(0, 99) < 60, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
